// File: rtl/f1_start_ctrl.sv
// f1_start_ctrl: paces the start-light FSM, randomises lights-out, times reactions and flags false starts
module f1_start_ctrl #(
    parameter int TICK_DIV  = 50,
    parameter int DELAY_MIN = 16,
    parameter int RT_W      = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            trigger,
    input  logic            react,
    input  logic [7:0]      lights_in,
    output logic            light_en,
    output logic            lights_out,
    output logic            rt_valid,
    output logic [RT_W-1:0] rt_cycles,
    output logic            false_start,
    output logic            busy
);
    localparam int TW = $clog2(TICK_DIV);
    localparam int DW = $clog2(DELAY_MIN + 128);
    localparam logic [TW-1:0] TLAST = TW'(TICK_DIV - 1);
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] RAMP = 3'd1;
    localparam logic [2:0] HOLD = 3'd2;
    localparam logic [2:0] GO   = 3'd3;
    localparam logic [2:0] DONE = 3'd4;
    localparam logic [2:0] JUMP = 3'd5;

    logic [2:0]      state_q, state_d;
    logic [TW-1:0]   tick_q, tick_d;
    logic [DW-1:0]   dly_q, dly_d;
    logic [RT_W-1:0] rt_q, rt_d;
    logic [RT_W-1:0] rtc_q, rtc_d;
    logic            rtv_q, rtv_d;
    logic            fs_q, fs_d;
    logic [6:0]      lfsr_q;
    logic            tick_hit, expire;

    // a react in the same cycle as a pending step always wins: no step, no lights-out
    always_comb begin
        tick_hit   = tick_q == TLAST;
        expire     = state_q == HOLD && dly_q == DW'(1) && !react;
        lights_out = expire;
        light_en   = expire
                   || (state_q == RAMP && tick_hit && !react && lights_in != 8'hFF)
                   || (state_q == JUMP && tick_hit && lights_in != 8'h00);
        state_d    = state_q;
        tick_d     = (state_q == RAMP || state_q == JUMP) ? (tick_hit ? '0 : tick_q + TW'(1)) : tick_q;
        dly_d      = state_q == HOLD ? dly_q - DW'(1) : dly_q;
        rt_d       = (state_q == GO && rt_q != '1) ? rt_q + RT_W'(1) : rt_q;
        rtc_d      = rtc_q;
        rtv_d      = 1'b0;
        fs_d       = fs_q;
        case (state_q)
            IDLE: if (trigger && lights_in == 8'h00) begin
                state_d = RAMP;
                tick_d  = '0;
                fs_d    = 1'b0;
            end
            RAMP: if (react) begin
                state_d = JUMP;
                tick_d  = '0;
                fs_d    = 1'b1;
            end else if (lights_in == 8'hFF) begin
                state_d = HOLD;
                dly_d   = DW'(DELAY_MIN) + DW'(lfsr_q);
            end
            HOLD: if (react) begin
                state_d = JUMP;
                tick_d  = '0;
                fs_d    = 1'b1;
            end else if (dly_q == DW'(1)) begin
                state_d = GO;
                rt_d    = RT_W'(1);
            end
            GO: if (react) begin
                state_d = DONE;
                rtc_d   = rt_q;
                rtv_d   = 1'b1;
            end
            DONE: state_d = IDLE;
            JUMP: if (lights_in == 8'h00) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            tick_q  <= '0;
            dly_q   <= '0;
            rt_q    <= '0;
            rtc_q   <= '0;
            rtv_q   <= 1'b0;
            fs_q    <= 1'b0;
            lfsr_q  <= 7'h01;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            dly_q   <= dly_d;
            rt_q    <= rt_d;
            rtc_q   <= rtc_d;
            rtv_q   <= rtv_d;
            fs_q    <= fs_d;
            lfsr_q  <= {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
        end
    end

    assign rt_cycles   = rtc_q;
    assign rt_valid    = rtv_q;
    assign false_start = fs_q;
    assign busy        = state_q != IDLE;
endmodule
